walk_service_ctrl: RTL and testbench

- Intersection phase controller; the consumer side of the walk register.
- Samples the latched pedestrian requests (WR_Out_1/WR_Out_2) and inserts an all-red WALK phase when any request is pending.
- Issues the single-cycle WR_Reset pulse that clears the walk register once requests are taken.
- Drives main/side vehicle lamps and the two walk lamps.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/phase_timer.sv | 30 +++
 rtl/walk_service_ctrl.sv | 148 ++++++++++++++
 tb/tb_walk_service_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp codes for the intersection controller.
package traffic_pkg;

    // Controller phases in cycle order; encoding 3'd7 is unused.
    typedef enum logic [2:0] {
        RED2   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        RED1   = 3'd3,
        WALK   = 3'd4,
        SIDE_G = 3'd5,
        SIDE_Y = 3'd6
    } state_e;

    // Lamp codes, {red,yellow,green}, one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each controller phase; holds at zero.
module phase_timer #(
    parameter int unsigned       W       = 4,
    parameter logic [W-1:0]      RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Reload on strobe, otherwise count down towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/walk_service_ctrl.sv
// Intersection phase controller serving latched pedestrian requests with an
// all-red WALK phase. Optional macro WALK_FLASH_EN flashes the walk lamps
// during the last FLASH_T cycles of WALK.
module walk_service_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_W = 4,
    parameter int unsigned GREEN_T = 8,
    parameter int unsigned SIDE_T  = 5,
    parameter int unsigned YEL_T   = 3,
    parameter int unsigned RED_T   = 2,
    parameter int unsigned WALK_T  = 6,
    parameter int unsigned FLASH_T = 2
) (
    input  logic       clk,
    input  logic       g_reset,
    input  logic       WR_Out_1,
    input  logic       WR_Out_2,
    output logic       WR_Reset,
    output logic [2:0] Main_Lights,
    output logic [2:0] Side_Lights,
    output logic       Walk_1,
    output logic       Walk_2
);

    localparam logic [TIMER_W-1:0] RED_LD   = TIMER_W'(RED_T - 1);
    localparam logic [TIMER_W-1:0] GREEN_LD = TIMER_W'(GREEN_T - 1);
    localparam logic [TIMER_W-1:0] SIDE_LD  = TIMER_W'(SIDE_T - 1);
    localparam logic [TIMER_W-1:0] YEL_LD   = TIMER_W'(YEL_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LD  = TIMER_W'(WALK_T - 1);

    if (FLASH_T >= WALK_T) begin : g_bad_flash_t
        $error("FLASH_T must be smaller than WALK_T");
    end

    state_e             state_q, state_d;
    logic [1:0]         snap_q, snap_d;
    logic               wr_reset_q, wr_reset_d;
    logic [1:0]         req;
    logic               snap_now;
    logic               illegal;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_zero;
    logic               walk_on;

    assign req      = {WR_Out_2, WR_Out_1};
    assign snap_now = (state_q == RED1) && tmr_zero;

    phase_timer #(
        .W       (TIMER_W),
        .RST_VAL (RED_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (g_reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    // Snapshot and clear-pulse are taken on the last RED1 cycle, so the
    // pulse lands exactly on the first WALK cycle.
    always_comb begin
        snap_d     = snap_now ? req : snap_q;
        wr_reset_d = snap_now && (req != 2'b00);
    end

    // State, request snapshot and WR_Reset registers.
    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            state_q    <= RED2;
            snap_q     <= 2'b00;
            wr_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            wr_reset_q <= wr_reset_d;
        end
    end

    // Next-state selection and timer reload on every phase change.
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            RED2:    if (tmr_zero) state_d = MAIN_G;
            MAIN_G:  if (tmr_zero) state_d = MAIN_Y;
            MAIN_Y:  if (tmr_zero) state_d = RED1;
            RED1:    if (tmr_zero) state_d = (req != 2'b00) ? WALK : SIDE_G;
            WALK:    if (tmr_zero) state_d = SIDE_G;
            SIDE_G:  if (tmr_zero) state_d = SIDE_Y;
            SIDE_Y:  if (tmr_zero) state_d = RED2;
            default: begin
                state_d = RED2;
                illegal = 1'b1;
            end
        endcase
        tmr_load = tmr_zero || illegal;
        case (state_d)
            MAIN_G:  tmr_load_val = GREEN_LD;
            MAIN_Y:  tmr_load_val = YEL_LD;
            WALK:    tmr_load_val = WALK_LD;
            SIDE_G:  tmr_load_val = SIDE_LD;
            SIDE_Y:  tmr_load_val = YEL_LD;
            default: tmr_load_val = RED_LD;
        endcase
    end

`ifdef WALK_FLASH_EN
    logic [TIMER_W-1:0] flash_idx;

    // Timer counts down through WALK; the flash window is its low FLASH_T
    // values, with the first flash cycle (index 0) off.
    always_comb begin
        flash_idx = TIMER_W'(FLASH_T - 1) - tmr_count;
        walk_on   = (tmr_count >= TIMER_W'(FLASH_T)) || flash_idx[0];
    end
`else
    // Walk lamps are steady for the whole WALK phase.
    always_comb begin
        walk_on = 1'b1;
    end
`endif

    // Lamp decode from the registered phase only.
    always_comb begin
        Main_Lights = LAMP_RED;
        Side_Lights = LAMP_RED;
        Walk_1      = 1'b0;
        Walk_2      = 1'b0;
        case (state_q)
            MAIN_G: Main_Lights = LAMP_GRN;
            MAIN_Y: Main_Lights = LAMP_YEL;
            SIDE_G: Side_Lights = LAMP_GRN;
            SIDE_Y: Side_Lights = LAMP_YEL;
            WALK: begin
                Walk_1 = snap_q[0] && walk_on;
                Walk_2 = snap_q[1] && walk_on;
            end
            default: ;
        endcase
    end

    assign WR_Reset = wr_reset_q;

endmodule

// File: tb/tb_walk_service_ctrl.sv
// Bench for walk_service_ctrl: timeline reference model, directed scenarios
// plus randomized request traffic.
module tb_walk_service_ctrl;

    localparam int GREEN_T = 8;
    localparam int SIDE_T  = 5;
    localparam int YEL_T   = 3;
    localparam int RED_T   = 2;
    localparam int WALK_T  = 6;
    localparam int FLASH_T = 2;

    // Period timeline boundaries (end of each segment, exclusive).
    localparam int E_R2 = RED_T;
    localparam int E_MG = E_R2 + GREEN_T;
    localparam int E_MY = E_MG + YEL_T;
    localparam int E_R1 = E_MY + RED_T;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk = 1'b0;
    logic       g_reset = 1'b0;
    logic       WR_Out_1 = 1'b0;
    logic       WR_Out_2 = 1'b0;
    logic       WR_Reset;
    logic [2:0] Main_Lights;
    logic [2:0] Side_Lights;
    logic       Walk_1;
    logic       Walk_2;

    int total = 0;
    int bad   = 0;

    // Reference model state: position in period, walk decision, snapshot.
    int         t_m    = 0;
    bit         walk_m = 0;
    logic [1:0] snap_m = 2'b00;
    bit         r1 = 0, r2 = 0;
    bit         rand_en = 0;

    walk_service_ctrl #(
        .TIMER_W (4),
        .GREEN_T (GREEN_T),
        .SIDE_T  (SIDE_T),
        .YEL_T   (YEL_T),
        .RED_T   (RED_T),
        .WALK_T  (WALK_T),
        .FLASH_T (FLASH_T)
    ) dut (
        .clk         (clk),
        .g_reset     (g_reset),
        .WR_Out_1    (WR_Out_1),
        .WR_Out_2    (WR_Out_2),
        .WR_Reset    (WR_Reset),
        .Main_Lights (Main_Lights),
        .Side_Lights (Side_Lights),
        .Walk_1      (Walk_1),
        .Walk_2      (Walk_2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t_m, obs, exp);
        end
    endtask

    function automatic int period_len(input bit walk);
        return E_R1 + (walk ? WALK_T : 0) + SIDE_T + YEL_T;
    endfunction

    // Expected outputs at period position t.
    task automatic expect_at(input int t, input bit walk, input logic [1:0] snap,
                             output logic [2:0] mn, output logic [2:0] sd,
                             output logic w1, output logic w2, output logic wr);
        int e_wk, e_sg, e_sy, k;
        bit on;
        e_wk = E_R1 + (walk ? WALK_T : 0);
        e_sg = e_wk + SIDE_T;
        e_sy = e_sg + YEL_T;
        mn = RED; sd = RED; w1 = 0; w2 = 0; wr = 0;
        if (t >= E_R2 && t < E_MG) mn = GRN;
        else if (t >= E_MG && t < E_MY) mn = YEL;
        else if (t >= E_R1 && t < e_wk) begin
            k  = t - E_R1;
            on = 1;
`ifdef WALK_FLASH_EN
            if (k >= WALK_T - FLASH_T) on = ((k - (WALK_T - FLASH_T)) % 2) == 1;
`endif
            w1 = snap[0] & on;
            w2 = snap[1] & on;
            wr = (k == 0);
        end
        else if (t >= e_wk && t < e_sg) sd = GRN;
        else if (t >= e_sg && t < e_sy) sd = YEL;
    endtask

    task automatic check_all();
        logic [2:0] mn, sd;
        logic w1, w2, wr;
        expect_at(t_m, walk_m, snap_m, mn, sd, w1, w2, wr);
        chk("main", Main_Lights, mn);
        chk("side", Side_Lights, sd);
        chk("walk1", {2'b00, Walk_1}, {2'b00, w1});
        chk("walk2", {2'b00, Walk_2}, {2'b00, w2});
        chk("wr_reset", {2'b00, WR_Reset}, {2'b00, wr});
    endtask

    // One cycle: called at the negative edge; checks, drives, advances model.
    task automatic step();
        logic [2:0] mn, sd;
        logic w1, w2, wr;
        check_all();
        expect_at(t_m, walk_m, snap_m, mn, sd, w1, w2, wr);
        if (wr) begin
            r1 = 0;
            r2 = 0;
        end
        if (rand_en) begin
            if ($urandom_range(0, 24) == 0) r1 = 1;
            if ($urandom_range(0, 24) == 0) r2 = 1;
        end
        WR_Out_1 = r1;
        WR_Out_2 = r2;
        @(posedge clk);
        if (t_m == E_R1 - 1) begin
            snap_m = {r2, r1};
            walk_m = (snap_m != 2'b00);
        end
        t_m++;
        if (t_m >= period_len(walk_m)) t_m = 0;
        @(negedge clk);
    endtask

    // Step until the model reaches position t (optionally in a walk period).
    task automatic run_until(input int t, input bit need_walk);
        int n = 0;
        while (!(t_m == t && (!need_walk || walk_m)) && n < 200) begin
            step();
            n++;
        end
        total++;
        assert (n < 200) else begin
            bad++;
            $error("FAIL run_until observed=timeout expected=t%0d", t);
        end
    endtask

    // Asynchronous reset pulse mid-WALK at walk cycle k.
    task automatic reset_in_walk(input int k);
        run_until(E_R1 + k, 1);
        #2 g_reset = 1'b0;
        #1;
        chk("rst_main", Main_Lights, RED);
        chk("rst_side", Side_Lights, RED);
        chk("rst_walk", {1'b0, Walk_2, Walk_1}, 3'b000);
        chk("rst_wr", {2'b00, WR_Reset}, 3'b000);
        t_m = 0; walk_m = 0; snap_m = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_main", Main_Lights, RED);
        g_reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        g_reset = 1'b1;

        // No requests: several full periods.
        repeat (50) step();

        // Crossing 1 request held from MAIN_G.
        run_until(E_R2, 0);
        r1 = 1;
        repeat (30) step();

        // Both crossings.
        run_until(E_R2, 0);
        r1 = 1; r2 = 1;
        repeat (30) step();

        // Crossing 2 arrives one cycle after the snapshot: served next period.
        run_until(E_R1, 0);
        r2 = 1;
        repeat (60) step();

        // Reset mid-WALK (cycle 3), then at the WR_Reset cycle.
        r1 = 1;
        reset_in_walk(3);
        repeat (30) step();
        r2 = 1;
        reset_in_walk(0);
        repeat (40) step();

        // Random request traffic.
        rand_en = 1;
        repeat (700) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
